// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared constants and types for the SRAM read-side burst master.
//   SRAM_ADDR_W / SRAM_DATA_W : default word-address and word widths
//   sram_addr_t / sram_word_t : address and data word types
//   rd_state_t                : burst reader FSM states
// ---------------------------------------------------------------------------
package sram_pkg;

   localparam int SRAM_ADDR_W = 7;
   localparam int SRAM_DATA_W = 32;

   typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
   typedef logic [SRAM_DATA_W-1:0] sram_word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rd_state_t;

endpackage

// File: rtl/sram_rd_fifo.sv
// ---------------------------------------------------------------------------
// sram_rd_fifo
// Small synchronous FIFO buffering words returned from the SRAM before they
// are handed to the streaming output port.
//   clk, rst   : rising-edge clock, synchronous active-high clear
//   push, data : write one word (ignored when full unless popping too)
//   pop        : remove the head word (ignored when empty)
//   head       : current head word, forced to 0 while empty
//   count      : number of stored words, 0..DEPTH
//   empty      : no words stored
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sram_rd_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [CNT_W-1:0]  count,
   output logic              empty
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              full;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   // A full FIFO can still accept a word when the head leaves in the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   // Head is masked while empty so the output reads 0 out of reset.
   assign head    = empty ? '0 : mem[rd_ptr];

   // Storage array carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= data;
      end
   end

   // Pointer and occupancy bookkeeping; push+pop together keeps count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_burst_reader.sv
// ---------------------------------------------------------------------------
// sram_burst_reader
// Read-side master for the shared SRAM interface. A start command captures a
// base address and a word count; the block then issues one SRAM read per
// cycle (credit-limited by the output buffer) and streams the returned words
// out over a valid/ready port. It never writes the SRAM.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   start             : begin a burst (only honoured in IDLE)
//   base_addr, length : first word address and word count (0..2^ADDR_W)
//   busy, done        : burst in progress / one-cycle completion pulse
//   out_data, out_valid, out_ready : streamed word handshake
//   sram_addr, sram_addr_ready, sram_read_pulse, sram_write_pulse : SRAM request
//   sram_dataout      : SRAM read data, valid READ_LAT cycles after a pulse
// READ_LAT is 1..3 and FIFO_DEPTH a power of two no smaller than READ_LAT+2.
// ---------------------------------------------------------------------------
module sram_burst_reader
   import sram_pkg::*;
#(
   parameter int ADDR_W     = SRAM_ADDR_W,
   parameter int DATA_W     = SRAM_DATA_W,
   parameter int READ_LAT   = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_addr_ready,
   output logic              sram_read_pulse,
   output logic              sram_write_pulse,
   input  logic [DATA_W-1:0] sram_dataout
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LAT + 2) + 1;

   rd_state_t         state;
   logic [ADDR_W-1:0] next_addr;
   logic [ADDR_W:0]   burst_len;
   logic [ADDR_W:0]   issued;
   logic [READ_LAT-1:0] pend;

   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic              push;
   logic              pop;

   logic [OCC_W-1:0]  occupancy;
   logic              credit_ok;
   logic              inflight_zero;
   logic              last_leaving;

   assign sram_write_pulse = 1'b0;

   // Bit i of pend marks a read issued i+1 cycles ago; the top bit lines up
   // with the cycle its data is present on sram_dataout.
   assign push = pend[READ_LAT-1];
   assign pop  = out_valid && out_ready;

   sram_rd_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .data  (sram_dataout),
      .pop   (pop),
      .head  (out_data),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   assign out_valid = !fifo_empty;

   // Occupancy as it will stand after this edge, before any new read:
   // stored words plus reads in flight (including the one on the bus now),
   // minus the word leaving through the output. Issuing only while this is
   // below the depth means every outstanding read has a FIFO slot reserved.
   always_comb begin
      occupancy = OCC_W'(fifo_count) + OCC_W'(sram_read_pulse);
      for (int i = 0; i < READ_LAT; i++) begin
         occupancy = occupancy + OCC_W'(pend[i]);
      end
      if (pop) begin
         occupancy = occupancy - OCC_W'(1);
      end
   end

   assign credit_ok     = (occupancy < OCC_W'(FIFO_DEPTH));
   assign inflight_zero = (pend == '0) && !sram_read_pulse;
   // The FIFO drains to empty at this edge (or already is).
   assign last_leaving  = (fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop);

   // Capture-pending shift register; a reset throws away returning reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= '0;
      end else begin
         pend[0] <= sram_read_pulse;
         for (int i = 1; i < READ_LAT; i++) begin
            pend[i] <= pend[i-1];
         end
      end
   end

   // Burst FSM with registered SRAM request and status outputs. The first
   // read is launched straight out of IDLE so it appears the cycle after
   // start; an empty FIFO always has room for it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         busy            <= 1'b0;
         done            <= 1'b0;
         sram_addr       <= '0;
         sram_addr_ready <= 1'b0;
         sram_read_pulse <= 1'b0;
         next_addr       <= '0;
         burst_len       <= '0;
         issued          <= '0;
      end else begin
         done            <= 1'b0;
         sram_addr_ready <= 1'b0;
         sram_read_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy      <= 1'b1;
                  burst_len <= length;
                  if (length == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state           <= ISSUE;
                     sram_addr       <= base_addr;
                     sram_addr_ready <= 1'b1;
                     sram_read_pulse <= 1'b1;
                     next_addr       <= base_addr + ADDR_W'(1);
                     issued          <= (ADDR_W+1)'(1);
                  end
               end
            end
            ISSUE: begin
               if (issued == burst_len) begin
                  state <= DRAIN;
               end else if (credit_ok) begin
                  sram_addr       <= next_addr;
                  sram_addr_ready <= 1'b1;
                  sram_read_pulse <= 1'b1;
                  // Address wraps modulo the memory depth by width.
                  next_addr       <= next_addr + ADDR_W'(1);
                  issued          <= issued + (ADDR_W+1)'(1);
               end
            end
            DRAIN: begin
               if (inflight_zero && last_leaving) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_sram_burst_reader
// Self-checking bench: an SRAM model preloaded with A000_0000+addr, a
// scoreboard queue of expected words filled when a burst is started and
// drained by a monitor on each output handshake, and one task per scenario.
// ---------------------------------------------------------------------------
module tb_sram_burst_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [6:0]  base_addr = '0;
   logic [7:0]  length = '0;
   logic        out_ready = 1'b1;
   logic [31:0] sram_dataout = '0;
   logic        busy;
   logic        done;
   logic [31:0] out_data;
   logic        out_valid;
   logic [6:0]  sram_addr;
   logic        sram_addr_ready;
   logic        sram_read_pulse;
   logic        sram_write_pulse;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [128];
   logic [31:0] exp_q [$];
   logic [6:0]  addr_log [$];

   int outstanding = 0;
   int max_out = 0;
   bit prev_stall = 0;
   logic [31:0] prev_data = '0;

   int first_pulse;
   int first_valid;
   int pulse_cnt;
   int last_hs;
   int ready_pat [4] = '{1, 0, 0, 1};

   sram_burst_reader #(
      .ADDR_W     (7),
      .DATA_W     (32),
      .READ_LAT   (1),
      .FIFO_DEPTH (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .base_addr        (base_addr),
      .length           (length),
      .busy             (busy),
      .done             (done),
      .out_data         (out_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .sram_addr        (sram_addr),
      .sram_addr_ready  (sram_addr_ready),
      .sram_read_pulse  (sram_read_pulse),
      .sram_write_pulse (sram_write_pulse),
      .sram_dataout     (sram_dataout)
   );

   always #5 clk = ~clk;

   // SRAM with one cycle of read latency; a poison value between reads
   // exposes any capture made on the wrong cycle.
   always @(posedge clk) begin
      sram_dataout <= sram_read_pulse ? mem[sram_addr] : 32'hDEAD_BEEF;
   end

   // Scoreboard and continuous protocol monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         outstanding = 0;
         prev_stall  = 0;
      end else begin
         checks++;
         if (sram_write_pulse !== 1'b0) begin
            errors++;
            $display("FAIL write_pulse: got %0b expected 0", sram_write_pulse);
         end
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data) begin
               errors++;
               $display("FAIL stall_stable: got valid=%0b data=%h expected valid=1 data=%h",
                        out_valid, out_data, prev_data);
            end
         end
         if (sram_read_pulse) outstanding++;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_extra: got word %h expected none", out_data);
            end else begin
               logic [31:0] expv;
               expv = exp_q.pop_front();
               if (out_data !== expv) begin
                  errors++;
                  $display("FAIL scoreboard_data: got %h expected %h", out_data, expv);
               end
            end
            outstanding--;
         end
         if (outstanding > max_out) max_out = outstanding;
         checks++;
         if (outstanding > 4) begin
            errors++;
            $display("FAIL credit_limit: got %0d outstanding expected <= 4", outstanding);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   // Drives a start in cycle 0 and queues the expected words; returns at
   // the start of cycle 1.
   task automatic start_burst(input logic [6:0] b, input logic [7:0] len);
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = b;
      length    = len;
      for (int i = 0; i < int'(len); i++) begin
         logic [6:0] a;
         a = b + 7'(i);
         exp_q.push_back(32'hA000_0000 + 32'(a));
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Steps cycles until done (or the limit), logging pulses and handshakes.
   // Optionally applies the backpressure pattern and a mid-burst start.
   task automatic run_until_done(input int limit, input bit bp, input int inject_cyc,
                                 output int done_cyc);
      int cyc;
      cyc = 1;
      done_cyc = -1;
      first_pulse = -1;
      first_valid = -1;
      pulse_cnt = 0;
      last_hs = -1;
      addr_log.delete();
      while (cyc <= limit) begin
         @(negedge clk);
         if (sram_read_pulse) begin
            pulse_cnt++;
            addr_log.push_back(sram_addr);
            if (first_pulse < 0) first_pulse = cyc;
         end
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_valid && out_ready) last_hs = cyc;
         if (done) begin
            done_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
         cyc++;
         if (bp) out_ready = ready_pat[cyc % 4][0];
         if (cyc == inject_cyc) begin
            start     = 1'b1;
            base_addr = 7'd90;
            length    = 8'd3;
         end else begin
            start = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, out_valid, sram_read_pulse, sram_addr_ready, sram_write_pulse} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {busy, done, out_valid, sram_read_pulse, sram_addr_ready, sram_write_pulse});
      end
      checks++;
      if (out_data !== 32'h0 || sram_addr !== 7'h0) begin
         errors++;
         $display("FAIL reset_data: got data=%h addr=%0d expected 0/0", out_data, sram_addr);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_full_sweep;
      int dc;
      out_ready = 1'b1;
      start_burst(7'd0, 8'd128);
      run_until_done(200, 0, -1, dc);
      checks++;
      if (dc != 131) begin
         errors++; $display("FAIL sweep_done_cycle: got %0d expected 131", dc);
      end
      checks++;
      if (first_pulse != 1 || first_valid != 3) begin
         errors++;
         $display("FAIL sweep_latency: got pulse=%0d valid=%0d expected 1/3", first_pulse, first_valid);
      end
      checks++;
      if (pulse_cnt != 128 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL sweep_count: got pulses=%0d left=%0d expected 128/0", pulse_cnt, exp_q.size());
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL sweep_busy_done: got %0b expected 1", busy);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL sweep_after: got busy=%0b done=%0b expected 0/0", busy, done);
      end
   endtask

   task automatic test_wrap;
      int dc;
      int expa [4] = '{126, 127, 0, 1};
      start_burst(7'd126, 8'd4);
      run_until_done(50, 0, -1, dc);
      checks++;
      if (dc != 7) begin
         errors++; $display("FAIL wrap_done_cycle: got %0d expected 7", dc);
      end
      checks++;
      if (addr_log.size() != 4) begin
         errors++; $display("FAIL wrap_pulses: got %0d expected 4", addr_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (int'(addr_log[i]) != expa[i]) begin
               errors++;
               $display("FAIL wrap_addr%0d: got %0d expected %0d", i, addr_log[i], expa[i]);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL wrap_left: got %0d expected 0", exp_q.size());
      end
   endtask

   task automatic test_zero_length;
      int dc;
      start_burst(7'd7, 8'd0);
      run_until_done(20, 0, -1, dc);
      checks++;
      if (dc != 1) begin
         errors++; $display("FAIL zero_done_cycle: got %0d expected 1", dc);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL zero_busy: got %0b expected 1", busy);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         if (sram_read_pulse) pulse_cnt++;
         if (out_valid) first_valid = 99;
      end
      checks++;
      if (pulse_cnt != 0 || first_valid != -1) begin
         errors++;
         $display("FAIL zero_activity: got pulses=%0d valid_at=%0d expected 0/-1", pulse_cnt, first_valid);
      end
   endtask

   task automatic test_backpressure;
      int dc;
      max_out = 0;
      out_ready = 1'b0;
      start_burst(7'd10, 8'd16);
      run_until_done(300, 1, -1, dc);
      checks++;
      if (dc < 0 || dc != last_hs + 1) begin
         errors++;
         $display("FAIL bp_done: got done=%0d last_handshake=%0d expected done=last+1", dc, last_hs);
      end
      checks++;
      if (pulse_cnt != 16 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_count: got pulses=%0d left=%0d expected 16/0", pulse_cnt, exp_q.size());
      end
      checks++;
      if (max_out != 4) begin
         errors++; $display("FAIL bp_fill: got max outstanding %0d expected 4", max_out);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset_mid_burst;
      int dc;
      out_ready = 1'b1;
      start_burst(7'd0, 8'd32);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_state: got valid=%0b busy=%0b done=%0b expected 0/0/0",
                  out_valid, busy, done);
      end
      dc = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         if (done || out_valid || sram_read_pulse) dc++;
      end
      checks++;
      if (dc != 0) begin
         errors++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", dc);
      end
      start_burst(7'd5, 8'd2);
      run_until_done(30, 0, -1, dc);
      checks++;
      if (dc != 5 || pulse_cnt != 2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rst_mid_next: got done=%0d pulses=%0d left=%0d expected 5/2/0",
                  dc, pulse_cnt, exp_q.size());
      end
   endtask

   task automatic test_start_ignored;
      int dc;
      int act;
      out_ready = 1'b1;
      start_burst(7'd20, 8'd6);
      run_until_done(40, 0, 2, dc);
      start = 1'b0;
      checks++;
      if (dc != 9 || pulse_cnt != 6 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL ignore_burst: got done=%0d pulses=%0d left=%0d expected 9/6/0",
                  dc, pulse_cnt, exp_q.size());
      end
      checks++;
      if (addr_log.size() != 6 || addr_log[5] !== 7'd25) begin
         errors++; $display("FAIL ignore_addr: got last addr %0d expected 25", addr_log[$]);
      end
      act = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); @(negedge clk);
         if (done || busy || out_valid || sram_read_pulse) act++;
      end
      checks++;
      if (act != 0) begin
         errors++; $display("FAIL ignore_after: got %0d active cycles expected 0", act);
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + 32'(i);
      test_reset();
      test_full_sweep();
      test_wrap();
      test_zero_length();
      test_backpressure();
      test_reset_mid_burst();
      test_start_ignored();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
